// File: rtl/audio_pkg.sv
// Shared constants and types for the audio level meter chain.
package audio_pkg;

  localparam logic WS_LEFT     = 1'b0;
  localparam int   AUDIO_WIDTH = 32;
  localparam int   SYNC_MIN    = 2;

  // The receiver stays disarmed until it has seen one frame boundary.
  typedef enum logic {
    RX_DISARMED = 1'b0,
    RX_ARMED    = 1'b1
  } rx_state_e;

endpackage

// File: rtl/i2s_input_sync.sv
// Brings the asynchronous I2S pins into the clk domain and turns SCK rising
// edges into a one-cycle strobe, with ws and sd aligned to that strobe.
module i2s_input_sync
  import audio_pkg::*;
#(
  parameter int sync_stages = SYNC_MIN
) (
  input  logic clk,
  input  logic reset,
  input  logic i2s_sck,
  input  logic i2s_ws,
  input  logic i2s_sd,
  output logic sck_strobe,
  output logic ws_now,
  output logic sd_now
);

  logic [sync_stages-1:0] sck_sync;
  logic [sync_stages-1:0] ws_sync;
  logic [sync_stages-1:0] sd_sync;
  logic                   sck_prev;

  // All three pins share one depth so ws/sd line up with the sck edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync   <= '0;
      ws_sync    <= '0;
      sd_sync    <= '0;
      sck_prev   <= 1'b0;
      sck_strobe <= 1'b0;
      ws_now     <= 1'b0;
      sd_now     <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[sync_stages-2:0], i2s_sck};
      ws_sync    <= {ws_sync[sync_stages-2:0], i2s_ws};
      sd_sync    <= {sd_sync[sync_stages-2:0], i2s_sd};
      sck_prev   <= sck_sync[sync_stages-1];
      sck_strobe <= sck_sync[sync_stages-1] & ~sck_prev;
      ws_now     <= ws_sync[sync_stages-1];
      sd_now     <= sd_sync[sync_stages-1];
    end
  end

endmodule

// File: rtl/i2s_receiver.sv
// I2S deserializer: assembles left-justified channel words and presents them
// as valid/ready beats, dropping (and flagging) words the sink cannot take.
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int width       = AUDIO_WIDTH,
  parameter int sync_stages = SYNC_MIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i2s_sck,
  input  logic             i2s_ws,
  input  logic             i2s_sd,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_is_left,
  output logic [width-1:0] o_data,
  output logic             o_overrun
);

  localparam int               count_w    = $clog2(width + 1);
  localparam logic [count_w-1:0] count_full = count_w'(width);

  logic             sck_strobe;
  logic             ws_now;
  logic             sd_now;
  logic [count_w-1:0] bit_count;
  logic [width-1:0] shift_reg;
  logic [width-1:0] shift_next;
  logic             ws_prev;
  logic             boundary;
  rx_state_e        state;
  rx_state_e        state_next;
  logic             word_done;
  logic [width-1:0] word_data;
  logic             word_left;

  i2s_input_sync #(
    .sync_stages(sync_stages)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .i2s_sck   (i2s_sck),
    .i2s_ws    (i2s_ws),
    .i2s_sd    (i2s_sd),
    .sck_strobe(sck_strobe),
    .ws_now    (ws_now),
    .sd_now    (sd_now)
  );

  assign boundary = sck_strobe && (ws_now != ws_prev);

  // Once the counter saturates no position matches, so extra bits fall away.
  always_comb begin
    shift_next = shift_reg;
    for (int i = 0; i < width; i++) begin
      if (bit_count == count_w'(width - 1 - i)) begin
        shift_next[i] = sd_now;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (boundary) begin
      state_next = RX_ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RX_DISARMED;
    end else begin
      state <= state_next;
    end
  end

  // The boundary bit is the LSB of the word that is ending (one-bit delay).
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count <= '0;
      shift_reg <= '0;
      ws_prev   <= 1'b0;
      word_done <= 1'b0;
      word_data <= '0;
      word_left <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (boundary) begin
        word_done <= (state == RX_ARMED);
        word_data <= shift_next;
        word_left <= (ws_prev == WS_LEFT);
        bit_count <= '0;
        shift_reg <= '0;
        ws_prev   <= ws_now;
      end else if (sck_strobe) begin
        shift_reg <= shift_next;
        if (bit_count != count_full) begin
          bit_count <= bit_count + 1'b1;
        end
      end
    end
  end

  // A completion coinciding with a transfer reloads without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_is_left <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (word_done) begin
        if (!o_valid || o_ready) begin
          o_valid   <= 1'b1;
          o_data    <= word_data;
          o_is_left <= word_left;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: an I2S transmitter model pushes the
// expected left-justified words, a monitor pops them on each accepted beat.
module tb_i2s_receiver;
  import audio_pkg::*;

  localparam int W    = 32;
  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i2s_sck = 1'b0;
  logic         i2s_ws = 1'b0;
  logic         i2s_sd = 1'b0;
  logic         o_valid;
  logic         o_ready = 1'b1;
  logic         o_is_left;
  logic [W-1:0] o_data;
  logic         o_overrun;

  int checks = 0;
  int errors = 0;
  int ovr_cycles = 0;
  int ovr_pulses = 0;
  int ovr_base_c = 0;
  int ovr_base_p = 0;
  logic ovr_last = 1'b0;
  logic hold_prev = 1'b0;
  logic [W-1:0] hold_data = '0;
  logic hold_left = 1'b0;
  logic [W-1:0] exp_data[$];
  logic exp_left[$];

  always #5 clk = ~clk;

  i2s_receiver #(
    .width(W),
    .sync_stages(SYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i2s_sck  (i2s_sck),
    .i2s_ws   (i2s_ws),
    .i2s_sd   (i2s_sd),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_is_left(o_is_left),
    .o_data   (o_data),
    .o_overrun(o_overrun)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expectation per accepted beat, checks held-word stability.
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
      ovr_last  = 1'b0;
    end else begin
      if (o_overrun) ovr_cycles++;
      if (o_overrun && !ovr_last) ovr_pulses++;
      ovr_last = o_overrun;
      if (hold_prev) begin
        check_output("hold_valid", 64'(o_valid), 64'd1);
        check_output("hold_data", 64'(o_data), 64'(hold_data));
        check_output("hold_left", 64'(o_is_left), 64'(hold_left));
      end
      if (o_valid && o_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=0x%0h expected=none", o_data);
        end else begin
          check_output("beat_data", 64'(o_data), 64'(exp_data.pop_front()));
          check_output("beat_left", 64'(o_is_left), 64'(exp_left.pop_front()));
        end
      end
      hold_prev = o_valid && !o_ready;
      hold_data = o_data;
      hold_left = o_is_left;
    end
  end

  task automatic drive_edge(input logic ws_v, input logic sd_v, input bit hook,
                            input logic [W-1:0] hook_data);
    i2s_sck = 1'b0;
    i2s_ws  = ws_v;
    i2s_sd  = sd_v;
    repeat (HALF) @(negedge clk);
    i2s_sck = 1'b1;
    if (hook) begin
      repeat (SYNC + 2) @(posedge clk);
      #1 o_ready = 1'b1;
      @(posedge clk);
      #1;
      check_output("no_bubble_valid", 64'(o_valid), 64'd1);
      check_output("no_bubble_data", 64'(o_data), 64'(hook_data));
      repeat (HALF - SYNC - 2) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  // Sends one slot of channel ch; the last bit goes out after ws has toggled.
  task automatic apply_stimulus(input logic ch, input logic [63:0] bits_in, input int slot,
                                input bit expect_it, input bit hook);
    logic [63:0]  bits;
    logic [W-1:0] word;
    bits = bits_in & ((64'd1 << slot) - 64'd1);
    if (slot >= W) word = W'(bits >> (slot - W));
    else           word = W'(bits << (W - slot));
    if (expect_it) begin
      exp_data.push_back(word);
      exp_left.push_back(ch == 1'b0);
    end
    for (int j = 0; j < slot; j++) begin
      drive_edge((j == slot - 1) ? ~ch : ch, bits[slot-1-j], hook && (j == slot - 1), word);
    end
  endtask

  task automatic apply_reset(input logic ready_v);
    i2s_sck = 1'b0;
    i2s_ws  = 1'b0;
    i2s_sd  = 1'b0;
    repeat (HALF) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    o_ready = ready_v;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_valid", 64'(o_valid), 64'd0);
    check_output("reset_data", 64'(o_data), 64'd0);
    check_output("reset_left", 64'(o_is_left), 64'd0);
    check_output("reset_overrun", 64'(o_overrun), 64'd0);
    exp_data.delete();
    exp_left.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    ovr_base_c = ovr_cycles;
    ovr_base_p = ovr_pulses;
  endtask

  task automatic end_test(input string name, input int exp_ovr);
    repeat (30) @(negedge clk);
    check_output({name, "_queue_empty"}, 64'(exp_data.size()), 64'd0);
    check_output({name, "_overrun_cycles"}, 64'(ovr_cycles - ovr_base_c), 64'(exp_ovr));
    check_output({name, "_overrun_pulses"}, 64'(ovr_pulses - ovr_base_p), 64'(exp_ovr));
  endtask

  initial begin
    $display("[TB] starting i2s_receiver bench");

    apply_reset(1'b1);
    apply_stimulus(1'b0, {$urandom, $urandom}, 32, 1'b0, 1'b0);
    apply_stimulus(1'b1, {$urandom, $urandom}, 32, 1'b1, 1'b0);
    apply_stimulus(1'b0, 64'h1234_5678, 32, 1'b1, 1'b0);
    apply_stimulus(1'b1, 64'h9ABC_DEF0, 32, 1'b1, 1'b0);
    end_test("frames32", 0);

    apply_reset(1'b1);
    apply_stimulus(1'b0, {$urandom, $urandom}, 16, 1'b0, 1'b0);
    apply_stimulus(1'b1, {$urandom, $urandom}, 16, 1'b1, 1'b0);
    apply_stimulus(1'b0, 64'hABCD, 16, 1'b1, 1'b0);
    apply_stimulus(1'b1, 64'h8001, 16, 1'b1, 1'b0);
    end_test("frames16", 0);

    apply_reset(1'b1);
    apply_stimulus(1'b0, {$urandom, $urandom}, 48, 1'b0, 1'b0);
    apply_stimulus(1'b1, {$urandom, $urandom}, 48, 1'b1, 1'b0);
    apply_stimulus(1'b0, 64'hDEAD_BEEF_FFFF, 48, 1'b1, 1'b0);
    apply_stimulus(1'b1, {$urandom, $urandom}, 48, 1'b1, 1'b0);
    end_test("frames48", 0);

    // Backpressure: the second completed word is dropped while the first is held.
    apply_reset(1'b0);
    apply_stimulus(1'b0, {$urandom, $urandom}, 32, 1'b0, 1'b0);
    apply_stimulus(1'b1, {$urandom, $urandom}, 32, 1'b1, 1'b0);
    apply_stimulus(1'b0, {$urandom, $urandom}, 32, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 o_ready = 1'b1;
    @(negedge clk);
    end_test("overrun", 1);

    // Transfer of the held word lands on the same cycle as the next completion.
    apply_reset(1'b0);
    apply_stimulus(1'b0, {$urandom, $urandom}, 32, 1'b0, 1'b0);
    apply_stimulus(1'b1, {$urandom, $urandom}, 32, 1'b1, 1'b0);
    apply_stimulus(1'b0, {$urandom, $urandom}, 32, 1'b1, 1'b1);
    end_test("coincide", 0);

    apply_reset(1'b1);
    apply_stimulus(1'b0, {$urandom, $urandom}, 32, 1'b0, 1'b0);
    apply_stimulus(1'b1, {$urandom, $urandom}, 32, 1'b1, 1'b0);
    for (int j = 0; j < 10; j++) drive_edge(1'b0, 1'($urandom), 1'b0, '0);
    end_test("pre_reset", 0);
    apply_reset(1'b1);
    apply_stimulus(1'b0, {$urandom, $urandom}, 32, 1'b0, 1'b0);
    apply_stimulus(1'b1, {$urandom, $urandom}, 32, 1'b1, 1'b0);
    apply_stimulus(1'b0, {$urandom, $urandom}, 32, 1'b1, 1'b0);
    end_test("post_reset", 0);

    apply_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'(i % 2), {$urandom, $urandom}, 16 + 8 * int'($urandom_range(0, 3)),
                     i > 0, 1'b0);
    end
    end_test("random", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
